// File: rtl/ws2812_pkg.sv
// WS2812 transmitter shared types and default timing.
// Defaults assume a 50 MHz clock.
`timescale 1ns/1ps
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int DEF_NUM_LEDS = 60;
    localparam int DEF_T0H_CYC  = 20;
    localparam int DEF_T1H_CYC  = 40;
    localparam int DEF_BIT_CYC  = 63;
    localparam int DEF_RST_CYC  = 2500;
    localparam int BITS_PER_LED = 24;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ws2812_bit_cell.sv
// Per-cell cycle counter; also times the latch gap.
// Produces the next dout level and an end-of-cell strobe.
`timescale 1ns/1ps
module ws2812_bit_cell
    import ws2812_pkg::*;
#(
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC,
    parameter int BIT_CYC = DEF_BIT_CYC,
    parameter int RST_CYC = DEF_RST_CYC,
    parameter int CW      = cnt_width(BIT_CYC, RST_CYC)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_cell_start,
    input  logic i_en,
    input  logic i_latch,
    input  logic i_bit,
    output logic o_dout_next,
    output logic o_cell_end
);

    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] T0H_L    = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_L    = CW'(T1H_CYC);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_last;
    logic [CW-1:0] w_high;

    always_comb begin
        w_last = i_latch ? RST_LAST : BIT_LAST;
        w_high = i_bit ? T1H_L : T0H_L;
    end

    assign o_cell_end  = i_en && (r_cnt == w_last);
    assign o_dout_next = i_en && !i_latch && (r_cnt < w_high);

    // Wraps to zero at each cell end, so cells and latch chain seamlessly.
    always_ff @(posedge clk) begin
        if (reset || i_cell_start) begin
            r_cnt <= '0;
        end else if (o_cell_end) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 frame transmitter: shifts a NUM_LEDS*24 bit frame MSB first,
// then holds the line low for the latch time.
`timescale 1ns/1ps
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T0H_CYC  = DEF_T0H_CYC,
    parameter int T1H_CYC  = DEF_T1H_CYC,
    parameter int BIT_CYC  = DEF_BIT_CYC,
    parameter int RST_CYC  = DEF_RST_CYC
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_start,
    input  logic [NUM_LEDS*BITS_PER_LED-1:0] i_data,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_dout
);

    localparam int W  = NUM_LEDS * BITS_PER_LED;
    localparam int BW = $clog2(W);
    localparam int CW = cnt_width(BIT_CYC, RST_CYC);
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC &&
          RST_CYC >= 1 && NUM_LEDS >= 1)) begin : g_bad_params
        $error("ws2812_tx: illegal timing or NUM_LEDS parameters");
    end

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_sreg;
    logic [BW-1:0]  r_bitcnt;
    logic           r_busy;
    logic           r_done;
    logic           r_dout;
    logic           w_capture;
    logic           w_last_bit;
    logic           w_cell_end;
    logic           w_dout_next;
    logic           w_busy_d;
    logic           w_done_d;
    logic           w_dout_d;

    assign w_capture  = (r_state == IDLE) && i_start;
    assign w_last_bit = (r_bitcnt == LAST_BIT);

    ws2812_bit_cell #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC),
        .RST_CYC (RST_CYC),
        .CW      (CW)
    ) u_cell (
        .clk          (clk),
        .reset        (reset),
        .i_cell_start (w_capture),
        .i_en         (r_state != IDLE),
        .i_latch      (r_state == LATCH),
        .i_bit        (r_sreg[W-1]),
        .o_dout_next  (w_dout_next),
        .o_cell_end   (w_cell_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_state_next = SEND;
            SEND:    if (w_cell_end && w_last_bit) w_state_next = LATCH;
            LATCH:   if (w_cell_end) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sreg   <= '0;
            r_bitcnt <= '0;
        end else if (w_capture) begin
            r_sreg   <= i_data;
            r_bitcnt <= '0;
        end else if (r_state == SEND && w_cell_end) begin
            r_sreg   <= {r_sreg[W-2:0], 1'b0};
            r_bitcnt <= w_last_bit ? '0 : r_bitcnt + 1'b1;
        end
    end

    // Outputs are a registered view of the state, one cycle behind it;
    // done fires on the first output cycle after busy drops.
    always_comb begin
        w_dout_d = (r_state == SEND) && w_dout_next;
        w_busy_d = (r_state != IDLE);
        w_done_d = r_busy && (r_state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_dout <= w_dout_d;
            r_busy <= w_busy_d;
            r_done <= w_done_d;
        end
    end

    assign o_dout = r_dout;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule
